// File: rtl/sm2201_camac_cycle_sequencer_if.sv
// Register-access port from the ISA decoder plus the CAMAC crate-bus pins.
// slave is the sequencer side, master the decoder/crate side.
interface sm2201_camac_cycle_sequencer_if;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_reg;
  logic [7:0]  req_wdata;
  logic [7:0]  rsp_rdata;
  logic        busy;
  logic        irq;
  logic [11:0] cb_addr;
  logic [15:0] cb_data_in;
  logic [15:0] cb_data_out;
  logic        cb_b_b1;
  logic        cb_cx1;
  logic        cb_prr;
  logic        cb_zk4;

  modport slave (
    input  req_valid, req_write, req_reg, req_wdata, cb_data_in, cb_prr, cb_zk4,
    output rsp_rdata, busy, irq, cb_addr, cb_data_out, cb_b_b1, cb_cx1
  );

  modport master (
    output req_valid, req_write, req_reg, req_wdata, cb_data_in, cb_prr, cb_zk4,
    input  rsp_rdata, busy, irq, cb_addr, cb_data_out, cb_b_b1, cb_cx1
  );
endinterface

// File: rtl/sm2201_camac_cycle_sequencer.sv
// SM2201 CAMAC cycle sequencer: small register file plus one timed crate read/write
// per start command (setup, strobe until acknowledge or timeout, hold, done).
module sm2201_camac_cycle_sequencer #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned STROBE_MIN   = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input logic isa_clk,
  input logic isa_reset,
  sm2201_camac_cycle_sequencer_if.slave bus
);

  localparam logic [2:0] REG_ADDR_L = 3'd0;
  localparam logic [2:0] REG_ADDR_H = 3'd1;
  localparam logic [2:0] REG_DATA_L = 3'd2;
  localparam logic [2:0] REG_DATA_H = 3'd3;
  localparam logic [2:0] REG_CMD    = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  localparam logic [7:0] SETUP_LAST   = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LAST  = 8'(STROBE_MIN - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;

  logic [11:0] addr;
  logic [11:0] cyc_addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        dir;
  logic        done;
  logic        timeout;
  logic [7:0]  rsp_q;
  logic [7:0]  rd_mux;
  logic        irq_q;

  logic        prr_meta;
  logic        prr_s;
  logic        lam_meta;
  logic        lam_s;

  logic        busy_c;
  logic        cx1_c;
  logic        b_b1_c;
  logic [15:0] data_out_c;

  logic        wr_en;
  logic        rd_en;
  logic        cmd_wr;
  logic        start;
  logic        clr;
  logic        strobe_ack;
  logic        strobe_tmo;

  assign wr_en  = bus.req_valid & bus.req_write;
  assign rd_en  = bus.req_valid & ~bus.req_write;
  assign cmd_wr = wr_en && (bus.req_reg == REG_CMD);
  assign start  = cmd_wr && bus.req_wdata[0] && !busy_c;
  assign clr    = cmd_wr && bus.req_wdata[2];

  // cnt restarts on every state change, so inside STROBE it holds elapsed clocks minus one.
  assign strobe_ack = (state == STROBE) && prr_s && (cnt >= STROBE_LAST);
  assign strobe_tmo = (state == STROBE) && !strobe_ack && (cnt == TIMEOUT_LAST);

  always_ff @(posedge isa_clk or posedge isa_reset) begin
    if (isa_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = start ? SETUP : IDLE;
      SETUP:      if (cnt == SETUP_LAST) state_nxt = STROBE;
      STROBE:     if (strobe_ack || strobe_tmo) state_nxt = HOLD;
      HOLD:       state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c     = 1'b0;
    cx1_c      = 1'b0;
    b_b1_c     = 1'b1;
    data_out_c = 16'h0000;
    case (state)
      SETUP, STROBE, HOLD: begin
        busy_c     = 1'b1;
        cx1_c      = (state == STROBE);
        b_b1_c     = dir;
        data_out_c = dir ? 16'h0000 : wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge isa_clk or posedge isa_reset) begin
    if (isa_reset) begin
      cnt <= 8'h00;
    end else if (state_nxt != state) begin
      cnt <= 8'h00;
    end else if (cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end

  // cb_prr / cb_zk4 are asynchronous and active low; keep them active high internally.
  always_ff @(posedge isa_clk or posedge isa_reset) begin
    if (isa_reset) begin
      prr_meta <= 1'b0;
      prr_s    <= 1'b0;
      lam_meta <= 1'b0;
      lam_s    <= 1'b0;
    end else begin
      prr_meta <= ~bus.cb_prr;
      prr_s    <= prr_meta;
      lam_meta <= ~bus.cb_zk4;
      lam_s    <= lam_meta;
    end
  end

  always_ff @(posedge isa_clk or posedge isa_reset) begin
    if (isa_reset) begin
      addr     <= 12'h000;
      wdata    <= 16'h0000;
      dir      <= 1'b0;
      cyc_addr <= 12'h000;
    end else begin
      if (wr_en && !busy_c) begin
        case (bus.req_reg)
          REG_ADDR_L: addr[7:0]   <= bus.req_wdata;
          REG_ADDR_H: addr[11:8]  <= bus.req_wdata[3:0];
          REG_DATA_L: wdata[7:0]  <= bus.req_wdata;
          REG_DATA_H: wdata[15:8] <= bus.req_wdata;
          REG_CMD:    dir         <= bus.req_wdata[1];
          default: ;
        endcase
      end
      if (start) begin
        cyc_addr <= addr;
      end
    end
  end

  // Setting a flag wins over a clear landing on the same edge.
  always_ff @(posedge isa_clk or posedge isa_reset) begin
    if (isa_reset) begin
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (state == HOLD) begin
        done <= 1'b1;
      end else if (clr || start) begin
        done <= 1'b0;
      end
      if (strobe_tmo) begin
        timeout <= 1'b1;
      end else if (clr || start) begin
        timeout <= 1'b0;
      end
    end
  end

  always_ff @(posedge isa_clk or posedge isa_reset) begin
    if (isa_reset) begin
      rdata <= 16'h0000;
    end else if (strobe_ack && dir) begin
      rdata <= bus.cb_data_in;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (bus.req_reg)
      REG_ADDR_L: rd_mux = addr[7:0];
      REG_ADDR_H: rd_mux = {4'h0, addr[11:8]};
      REG_DATA_L: rd_mux = rdata[7:0];
      REG_DATA_H: rd_mux = rdata[15:8];
      REG_CMD:    rd_mux = {6'b000000, dir, 1'b0};
      REG_STATUS: rd_mux = {4'h0, lam_s, timeout, done, busy_c};
      default:    rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge isa_clk or posedge isa_reset) begin
    if (isa_reset) begin
      rsp_q <= 8'h00;
      irq_q <= 1'b0;
    end else begin
      if (rd_en) begin
        rsp_q <= rd_mux;
      end
      irq_q <= lam_s | done;
    end
  end

  assign bus.rsp_rdata   = rsp_q;
  assign bus.busy        = busy_c;
  assign bus.irq         = irq_q;
  assign bus.cb_addr     = cyc_addr;
  assign bus.cb_data_out = data_out_c;
  assign bus.cb_b_b1     = b_b1_c;
  assign bus.cb_cx1      = cx1_c;

endmodule

// File: tb/tb_sm2201_camac_cycle_sequencer.sv
// Randomized bench for the CAMAC cycle sequencer against a cycle-schedule reference model,
// plus directed checks with hand-computed values.
module tb_sm2201_camac_cycle_sequencer;

  localparam int SC = 2;
  localparam int SM = 4;
  localparam int TO = 255;

  logic isa_clk = 1'b0;
  logic isa_reset = 1'b1;
  always #5 isa_clk = ~isa_clk;

  sm2201_camac_cycle_sequencer_if b();

  sm2201_camac_cycle_sequencer #(.SETUP_CYCLES(SC), .STROBE_MIN(SM), .TIMEOUT(TO)) dut (
    .isa_clk  (isa_clk),
    .isa_reset(isa_reset),
    .bus      (b)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  int crate_d = 0;
  int hi_cnt = 0;
  int last_len = 0;

  // Reference model: register contents plus a schedule counted in clocks since the start edge.
  logic [11:0] m_addr, m_cbaddr;
  logic [15:0] m_wdata, m_rdata;
  logic        m_dir, m_done, m_tmo, m_lam, m_zk_q1, m_irq;
  logic [7:0]  m_rsp;
  bit          m_act, m_to;
  int          m_n, m_k;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  function automatic int exp_len(input int d);
    int l;
    if (d == 0) return TO;
    l = (d + 2 > SM) ? d + 2 : SM;
    return (l > TO) ? TO : l;
  endfunction

  function automatic bit m_busy();
    return m_act && (m_n <= SC + m_k);
  endfunction

  task automatic m_reset();
    m_addr = '0; m_cbaddr = '0; m_wdata = '0; m_rdata = '0;
    m_dir = 0; m_done = 0; m_tmo = 0; m_lam = 0; m_zk_q1 = 0; m_irq = 0;
    m_rsp = '0; m_act = 0; m_to = 0; m_n = 0; m_k = 0;
  endtask

  task automatic m_step();
    bit         bz;
    bit         wr;
    logic [7:0] rv;
    logic [7:0] wd;
    bz = m_busy();
    wr = b.req_valid && b.req_write;
    wd = b.req_wdata;
    if (b.req_valid && !b.req_write) begin
      case (b.req_reg)
        3'd0: rv = m_addr[7:0];
        3'd1: rv = {4'h0, m_addr[11:8]};
        3'd2: rv = m_rdata[7:0];
        3'd3: rv = m_rdata[15:8];
        3'd4: rv = {6'b0, m_dir, 1'b0};
        3'd5: rv = {4'h0, m_lam, m_tmo, m_done, bz};
        default: rv = 8'h00;
      endcase
      m_rsp = rv;
    end
    m_irq = m_lam | m_done;
    if (wr && b.req_reg == 3'd4 && wd[2]) begin
      m_done = 0;
      m_tmo = 0;
    end
    if (m_act) begin
      m_n++;
      if (m_n == SC + m_k) begin
        if (m_to) m_tmo = 1;
        else if (m_dir) m_rdata = b.cb_data_in;
      end
      if (m_n == SC + m_k + 1) m_done = 1;
      if (m_n > SC + m_k + 1) m_act = 0;
    end
    if (wr && !bz) begin
      case (b.req_reg)
        3'd0: m_addr[7:0] = wd;
        3'd1: m_addr[11:8] = wd[3:0];
        3'd2: m_wdata[7:0] = wd;
        3'd3: m_wdata[15:8] = wd;
        3'd4: begin
          m_dir = wd[1];
          if (wd[0]) begin
            m_act = 1; m_n = 0;
            m_k = exp_len(crate_d);
            m_to = (crate_d == 0) || (crate_d + 2 > TO);
            m_cbaddr = m_addr;
            m_done = 0; m_tmo = 0;
          end
        end
        default: ;
      endcase
    end
    m_lam = m_zk_q1;
    m_zk_q1 = !b.cb_zk4;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge isa_clk or posedge isa_reset);
      if (isa_reset) m_reset();
      else m_step();
    end
  end

  // Crate: acknowledges on the negedge of the crate_d-th strobe clock (0 = never).
  initial begin
    b.cb_prr = 1'b1;
    forever begin
      @(negedge isa_clk);
      if (b.cb_cx1) begin
        hi_cnt++;
        if (crate_d != 0 && hi_cnt == crate_d) b.cb_prr = 1'b0;
      end else begin
        if (hi_cnt != 0) last_len = hi_cnt;
        hi_cnt = 0;
        b.cb_prr = 1'b1;
      end
    end
  end

  initial begin
    bit e_busy;
    forever begin
      @(negedge isa_clk);
      if (chk_en && !isa_reset) begin
        e_busy = m_busy();
        chk("busy", b.busy, e_busy);
        chk("cb_cx1", b.cb_cx1, m_act && m_n >= SC && m_n < SC + m_k);
        chk("cb_b_b1", b.cb_b_b1, e_busy ? m_dir : 1'b1);
        chk("cb_data_out", b.cb_data_out, (e_busy && !m_dir) ? m_wdata : 16'h0);
        chk("cb_addr", b.cb_addr, m_cbaddr);
        chk("irq", b.irq, m_irq);
        chk("rsp_rdata", b.rsp_rdata, m_rsp);
      end
    end
  end

  task automatic wr(input logic [2:0] r, input logic [7:0] d);
    @(negedge isa_clk);
    b.req_valid = 1; b.req_write = 1; b.req_reg = r; b.req_wdata = d;
    @(negedge isa_clk);
    b.req_valid = 0; b.req_write = 0;
  endtask

  task automatic rd(input logic [2:0] r, output logic [7:0] v);
    @(negedge isa_clk);
    b.req_valid = 1; b.req_write = 0; b.req_reg = r;
    @(negedge isa_clk);
    b.req_valid = 0;
    v = b.rsp_rdata;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (b.busy && i < 600) begin
      @(negedge isa_clk);
      i++;
    end
    chk("cycle_ends", b.busy, 1'b0);
    repeat (2) @(negedge isa_clk);
  endtask

  initial begin
    logic [7:0]  v;
    logic [11:0] ra;
    logic [15:0] rdat;
    int          i;
    b.req_valid = 0; b.req_write = 0; b.req_reg = 0; b.req_wdata = 0;
    b.cb_data_in = 16'h0; b.cb_zk4 = 1'b1;
    repeat (3) @(negedge isa_clk);
    isa_reset = 0;
    chk_en = 1;

    // 1: idle after reset
    repeat (300) @(negedge isa_clk);
    chk("t1_cx1", b.cb_cx1, 0);
    chk("t1_b_b1", b.cb_b_b1, 1);
    chk("t1_data_out", b.cb_data_out, 0);
    chk("t1_busy", b.busy, 0);
    chk("t1_rsp", b.rsp_rdata, 0);
    rd(3'd5, v); chk("t1_status", v, 8'h00);

    // 2: crate write, acknowledge on 3rd strobe clock
    wr(3'd0, 8'h34); wr(3'd1, 8'h01); wr(3'd2, 8'hCD); wr(3'd3, 8'hAB);
    crate_d = 3;
    wr(3'd4, 8'h01);
    chk("t2_busy", b.busy, 1);
    chk("t2_addr", b.cb_addr, 12'h134);
    chk("t2_b_b1", b.cb_b_b1, 0);
    chk("t2_data_out", b.cb_data_out, 16'hABCD);
    wait_idle();
    chk("t2_strobe_len", last_len, 5);
    rd(3'd5, v); chk("t2_status", v, 8'h02);

    // 3: crate read
    b.cb_data_in = 16'h5A5A;
    wr(3'd4, 8'h03);
    chk("t3_b_b1", b.cb_b_b1, 1);
    wait_idle();
    rd(3'd2, v); chk("t3_data_l", v, 8'h5A);
    rd(3'd3, v); chk("t3_data_h", v, 8'h5A);
    rd(3'd5, v); chk("t3_status", v, 8'h02);

    // 4: no acknowledge -> timeout
    crate_d = 0;
    b.cb_data_in = 16'h1234;
    wr(3'd4, 8'h03);
    wait_idle();
    chk("t4_strobe_len", last_len, 255);
    rd(3'd5, v); chk("t4_status", v, 8'h06);
    rd(3'd2, v); chk("t4_data_l", v, 8'h5A);
    rd(3'd3, v); chk("t4_data_h", v, 8'h5A);

    // 5: writes while busy
    crate_d = 6;
    wr(3'd4, 8'h01);
    wr(3'd0, 8'hFF);
    wr(3'd4, 8'h01);
    wr(3'd4, 8'h04);
    chk("t5_addr", b.cb_addr, 12'h134);
    wait_idle();
    chk("t5_strobe_len", last_len, 8);
    rd(3'd0, v); chk("t5_addr_l", v, 8'h34);
    rd(3'd5, v); chk("t5_status", v, 8'h02);
    wr(3'd4, 8'h04);
    rd(3'd5, v); chk("t5_status_clr", v, 8'h00);

    // 6: LAM and reset mid-strobe
    b.cb_zk4 = 1'b0;
    repeat (2) @(negedge isa_clk);
    chk("t6_irq_early", b.irq, 0);
    @(negedge isa_clk);
    chk("t6_irq", b.irq, 1);
    rd(3'd5, v); chk("t6_status", v, 8'h08);
    b.cb_zk4 = 1'b1;
    repeat (4) @(negedge isa_clk);
    crate_d = 0;
    wr(3'd4, 8'h01);
    i = 0;
    while (!b.cb_cx1 && i < 20) begin @(negedge isa_clk); i++; end
    chk("t6_in_strobe", b.cb_cx1, 1);
    repeat (3) @(negedge isa_clk);
    #2 isa_reset = 1;
    #1;
    chk("t6_rst_cx1", b.cb_cx1, 0);
    chk("t6_rst_busy", b.busy, 0);
    chk("t6_rst_b_b1", b.cb_b_b1, 1);
    chk("t6_rst_data_out", b.cb_data_out, 0);
    chk("t6_rst_addr", b.cb_addr, 0);
    chk("t6_rst_irq", b.irq, 0);
    chk("t6_rst_rsp", b.rsp_rdata, 0);
    repeat (3) @(negedge isa_clk);
    isa_reset = 0;
    rd(3'd0, v); chk("t6_addr_l", v, 8'h00);
    rd(3'd5, v); chk("t6_status", v, 8'h00);

    // random transactions, checked cycle by cycle against the model
    for (int t = 0; t < 40; t++) begin
      ra = 12'($urandom);
      rdat = 16'($urandom);
      wr(3'd0, ra[7:0]);
      wr(3'd1, {4'($urandom), ra[11:8]});
      wr(3'd2, rdat[7:0]);
      wr(3'd3, rdat[15:8]);
      crate_d = ($urandom_range(0, 12) == 0) ? 0 : int'($urandom_range(1, 9));
      b.cb_data_in = 16'($urandom);
      if ($urandom_range(0, 3) == 0) b.cb_zk4 = 1'($urandom);
      wr(3'd4, {5'($urandom), 1'($urandom), 1'($urandom), 1'b1});
      repeat ($urandom_range(0, 3)) begin
        if ($urandom_range(0, 1) == 1) rd(3'($urandom), v);
        else wr(3'($urandom_range(0, 4)), 8'($urandom) & 8'hFE);
      end
      wait_idle();
      rd(3'($urandom), v);
      rd(3'd5, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
